// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM read handshake, decode-side valid/ready queue port and branch redirect.
// The master modport is the fetch unit; the slave modport is the ROM controller / decode side.
interface instr_fetch_unit_if;

  // ROM controller handshake
  logic        MemRead;
  logic [31:0] MemAddr;
  logic        DataValid;
  logic [31:0] DataOut;

  // Decode handshake
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;

  // Branch redirect
  logic        Redirect;
  logic [31:0] RedirectPC;

  modport master (
    output MemRead,
    output MemAddr,
    input  DataValid,
    input  DataOut,
    output Instr,
    output InstrPC,
    output InstrValid,
    input  InstrReady,
    input  Redirect,
    input  RedirectPC
  );

  modport slave (
    input  MemRead,
    input  MemAddr,
    output DataValid,
    output DataOut,
    input  Instr,
    input  InstrPC,
    input  InstrValid,
    output InstrReady,
    output Redirect,
    output RedirectPC
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one ROM word read at a time and buffers
// returned words in a 2-entry queue drained by decode; a redirect flushes and restarts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   Reset_L,
  instr_fetch_unit_if.master     bus_io
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitAck,
    StWaitData
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       mem_addr_q;
  logic              mem_read_q;
  logic              discard_q;

  logic [1:0][31:0]  q_data_q, q_data_d;
  logic [1:0][31:0]  q_pc_q,   q_pc_d;
  logic [1:0]        count_q,  count_d;

  logic              issue;
  logic              capture;
  logic              push;
  logic              pop;
  logic [31:0]       redirect_pc;
  logic              unused_redirect_lsb;

  assign redirect_pc         = {bus_io.RedirectPC[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus_io.RedirectPC[1:0];

  // Issue only when the ROM controller reports idle, so a freshly reset controller is never
  // handed a request before its own reset has completed.
  assign issue   = (state_q == StIdle) && !bus_io.Redirect && bus_io.DataValid &&
                   (count_q < 2'd2);
  assign capture = (state_q == StWaitData) && bus_io.DataValid;
  assign push    = capture && !discard_q && !bus_io.Redirect;
  assign pop     = (count_q != 2'd0) && bus_io.InstrReady;

  // Queue next state: entry 0 is the head; a pop shifts entry 1 down.
  always_comb begin
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;
    count_d  = count_q;
    if (bus_io.Redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          q_data_d[0] = q_data_q[1];
          q_pc_d[0]   = q_pc_q[1];
          count_d     = count_q - 2'd1;
        end
        2'b10: begin
          q_data_d[count_q[0]] = bus_io.DataOut;
          q_pc_d[count_q[0]]   = mem_addr_q;
          count_d              = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            q_data_d[0] = bus_io.DataOut;
            q_pc_d[0]   = mem_addr_q;
          end else begin
            q_data_d[0] = q_data_q[1];
            q_pc_d[0]   = q_pc_q[1];
            q_data_d[1] = bus_io.DataOut;
            q_pc_d[1]   = mem_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      q_data_q <= '0;
      q_pc_q   <= '0;
      count_q  <= 2'd0;
    end else begin
      q_data_q <= q_data_d;
      q_pc_q   <= q_pc_d;
      count_q  <= count_d;
    end
  end

  // Request FSM with registered MemRead/MemAddr.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_read_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            mem_addr_q <= pc_q;
            mem_read_q <= 1'b1;
            pc_q       <= pc_q + 32'd4;
            state_q    <= StReq;
          end
        end
        StReq: begin
          mem_read_q <= 1'b0;
          state_q    <= StWaitAck;
        end
        StWaitAck: begin
          if (!bus_io.DataValid) begin
            state_q <= StWaitData;
          end
        end
        StWaitData: begin
          if (bus_io.DataValid) begin
            discard_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // The ROM access in flight is not aborted; its word is dropped when it returns.
      // A redirect landing on the capture edge drops that word directly, so no mark is left.
      if (bus_io.Redirect) begin
        pc_q <= redirect_pc;
        if ((state_q != StIdle) && !capture) begin
          discard_q <= 1'b1;
        end
      end
    end
  end

  assign bus_io.MemRead    = mem_read_q;
  assign bus_io.MemAddr    = mem_addr_q;
  assign bus_io.Instr      = q_data_q[0];
  assign bus_io.InstrPC    = q_pc_q[0];
  assign bus_io.InstrValid = (count_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a cycle-accurate ROM controller model that
// returns (addr ^ 32'hC0DE_0000) five cycles after latching each request.
module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic Reset_L;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .bus_io (bus)
  );

  // ROM controller model: idle = DataValid high; latches MemRead, drops DataValid for 5 cycles.
  logic        rom_dv;
  logic        rom_busy;
  logic        rom_hold;
  logic [2:0]  rom_cnt;
  logic [31:0] rom_addr;
  logic [31:0] rom_do;

  assign bus.DataValid = rom_dv && !rom_hold;
  assign bus.DataOut   = rom_do;

  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rom_dv   <= 1'b1;
      rom_busy <= 1'b0;
      rom_cnt  <= 3'd0;
      rom_addr <= 32'd0;
      rom_do   <= 32'd0;
    end else if (rom_busy) begin
      if (rom_cnt == 3'd0) begin
        rom_dv   <= 1'b1;
        rom_do   <= rom_addr ^ 32'hC0DE_0000;
        rom_busy <= 1'b0;
      end else begin
        rom_cnt <= rom_cnt - 3'd1;
      end
    end else if (bus.MemRead) begin
      rom_addr <= bus.MemAddr;
      rom_dv   <= 1'b0;
      rom_busy <= 1'b1;
      rom_cnt  <= 3'd4;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int req_cyc;
  int prev_cyc;
  int r_cyc;
  int hits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Wait (bounded) for the next MemRead pulse, sampled on the falling edge.
  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.MemRead && n < 40);
    req_cyc = cyc;
    chk({tag, "_req"}, 32'(bus.MemRead), 32'd1);
    chk({tag, "_addr"}, bus.MemAddr, exp_addr);
  endtask

  // Full fetch: request, 1-cycle pulse, word visible at the queue head 7 cycles after REQ.
  task automatic fetch_check(input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                             input logic [31:0] exp_instr, input string tag);
    wait_req(exp_addr, tag);
    @(negedge CLK);
    chk({tag, "_width"}, 32'(bus.MemRead), 32'd0);
    repeat (6) @(negedge CLK);
    chk({tag, "_valid"}, 32'(bus.InstrValid), 32'd1);
    chk({tag, "_pc"}, bus.InstrPC, exp_pc);
    chk({tag, "_instr"}, bus.Instr, exp_instr);
    chk({tag, "_hold"}, bus.MemAddr, exp_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_L        = 1'b0;
    rom_hold       = 1'b0;
    bus.InstrReady = 1'b1;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_memread", 32'(bus.MemRead), 32'd0);
    chk("rst_memaddr", bus.MemAddr, 32'h0000_0100);
    chk("rst_instr", bus.Instr, 32'd0);
    chk("rst_instrpc", bus.InstrPC, 32'd0);
    chk("rst_valid", 32'(bus.InstrValid), 32'd0);
    Reset_L = 1'b1;

    // Streaming from RESET_PC, one word per 8 cycles
    fetch_check(32'h0000_0100, 32'h0000_0100, 32'hC0DE_0100, "f100");
    prev_cyc = req_cyc;
    fetch_check(32'h0000_0104, 32'h0000_0104, 32'hC0DE_0104, "f104");
    chk("period1", req_cyc - prev_cyc, 32'd8);
    prev_cyc = req_cyc;
    fetch_check(32'h0000_0108, 32'h0000_0108, 32'hC0DE_0108, "f108");
    chk("period2", req_cyc - prev_cyc, 32'd8);

    // Redirect in IDLE to 0 with decode stalled; request follows two cycles later
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0000;
    bus.InstrReady = 1'b0;
    r_cyc = cyc;
    @(negedge CLK);
    bus.Redirect = 1'b0;
    chk("rd_idle_flush", 32'(bus.InstrValid), 32'd0);
    chk("rd_idle_noissue", 32'(bus.MemRead), 32'd0);
    fetch_check(32'h0000_0000, 32'h0000_0000, 32'hC0DE_0000, "f000");
    chk("rd_idle_latency", req_cyc - r_cyc, 32'd2);
    fetch_check(32'h0000_0004, 32'h0000_0000, 32'hC0DE_0000, "f004");

    // Queue full: no further requests
    hits = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.MemRead) hits++;
    end
    chk("full_noissue", hits, 32'd0);
    chk("full_head", bus.InstrPC, 32'h0000_0000);

    // One-cycle pop frees a slot; next fetch is 0x8 behind 0x4
    bus.InstrReady = 1'b1;
    @(negedge CLK);
    bus.InstrReady = 1'b0;
    chk("pop1_pc", bus.InstrPC, 32'h0000_0004);
    chk("pop1_instr", bus.Instr, 32'hC0DE_0004);
    fetch_check(32'h0000_0008, 32'h0000_0004, 32'hC0DE_0004, "f008");
    bus.InstrReady = 1'b1;
    @(negedge CLK);
    bus.InstrReady = 1'b0;
    chk("pop2_pc", bus.InstrPC, 32'h0000_0008);

    // Redirect during WAIT_DATA with one queued entry
    wait_req(32'h0000_000C, "f00c");
    repeat (3) @(negedge CLK);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_2003;
    bus.InstrReady = 1'b1;
    @(negedge CLK);
    bus.Redirect = 1'b0;
    chk("rd_wd_flush", 32'(bus.InstrValid), 32'd0);
    repeat (3) @(negedge CLK);
    chk("rd_wd_drop", 32'(bus.InstrValid), 32'd0);
    fetch_check(32'h0000_2000, 32'h0000_2000, 32'hC0DE_2000, "f2000");

    // Redirect coinciding with the DataValid rise
    wait_req(32'h0000_2004, "f2004");
    repeat (6) @(negedge CLK);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFFC;
    @(negedge CLK);
    bus.Redirect = 1'b0;
    chk("rd_cap_drop", 32'(bus.InstrValid), 32'd0);
    fetch_check(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3F21_FFFC, "ftop");
    fetch_check(32'h0000_0000, 32'h0000_0000, 32'hC0DE_0000, "fwrap");

    // Asynchronous reset in WAIT_ACK with a word queued
    bus.InstrReady = 1'b0;
    wait_req(32'h0000_0004, "f004b");
    @(negedge CLK);
    chk("pre_rst_valid", 32'(bus.InstrValid), 32'd1);
    #2;
    Reset_L  = 1'b0;
    rom_hold = 1'b1;
    #1;
    chk("arst_memread", 32'(bus.MemRead), 32'd0);
    chk("arst_memaddr", bus.MemAddr, 32'h0000_0100);
    chk("arst_valid", 32'(bus.InstrValid), 32'd0);
    chk("arst_instr", bus.Instr, 32'd0);
    chk("arst_instrpc", bus.InstrPC, 32'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.MemRead) hits++;
    end
    chk("arst_wait_dv", hits, 32'd0);
    rom_hold = 1'b0;
    fetch_check(32'h0000_0100, 32'h0000_0100, 32'hC0DE_0100, "frst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
